// File: rtl/axi_default_slave_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) between an interconnect port and the default slave.
interface axi_default_slave_if #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) ();
   logic                  awvalid;
   logic                  awready;
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wlast;
   logic                  bvalid;
   logic                  bready;
   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic                  rvalid;
   logic                  rready;
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;

   modport slave (
      input  awvalid, awid, awaddr, wvalid, wdata, wlast, bready,
             arvalid, arid, araddr, arlen, rready,
      output awready, wready, bvalid, bid, bresp,
             arready, rvalid, rid, rdata, rresp, rlast
   );

   modport master (
      output awvalid, awid, awaddr, wvalid, wdata, wlast, bready,
             arvalid, arid, araddr, arlen, rready,
      input  awready, wready, bvalid, bid, bresp,
             arready, rvalid, rid, rdata, rresp, rlast
   );
endinterface

// File: rtl/axi_default_slave.sv
// AXI4 default slave: completes every write and read burst with DECERR, read data all zeros.
// Optional error log (err_cnt/err_addr) enabled by defining AXI_DEFSLV_ERRLOG_EN.
module axi_default_slave #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   axi_default_slave_if.slave    s,
   output logic [15:0]           err_cnt,
   output logic [ADDR_WIDTH-1:0] err_addr
);
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   w_state_e              w_state_q, w_state_d;
   logic                  awready_q, awready_d;
   logic                  wready_q,  wready_d;
   logic                  bvalid_q,  bvalid_d;
   logic [ID_WIDTH-1:0]   bid_q,     bid_d;
   logic [1:0]            bresp_q,   bresp_d;

   r_state_e              r_state_q, r_state_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q,  rvalid_d;
   logic [ID_WIDTH-1:0]   rid_q,     rid_d;
   logic [1:0]            rresp_q,   rresp_d;
   logic                  rlast_q,   rlast_d;
   logic [7:0]            arlen_q,   arlen_d;
   logic [7:0]            beat_q,    beat_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign aw_hs = s.awvalid && awready_q;
   assign w_hs  = s.wvalid  && wready_q;
   assign b_hs  = s.bready  && bvalid_q;
   assign ar_hs = s.arvalid && arready_q;
   assign r_hs  = s.rready  && rvalid_q;

   // Write path: accept AW, sink beats up to WLAST, hold DECERR response until BREADY.
   always_comb begin
      w_state_d = w_state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      unique case (w_state_q)
         W_IDLE: begin
            awready_d = 1'b1;
            if (aw_hs) begin
               bid_d     = s.awid;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (w_hs && s.wlast) begin
               wready_d  = 1'b0;
               bvalid_d  = 1'b1;
               bresp_d   = RESP_DECERR;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (b_hs) begin
               bvalid_d  = 1'b0;
               bresp_d   = 2'b00;
               awready_d = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read path: accept AR, return ARLEN+1 zero beats with DECERR; beat counter stops at ARLEN.
   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rid_d     = rid_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      arlen_d   = arlen_q;
      beat_d    = beat_q;
      unique case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (ar_hs) begin
               rid_d     = s.arid;
               arlen_d   = s.arlen;
               beat_d    = 8'd0;
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rresp_d   = RESP_DECERR;
               rlast_d   = (s.arlen == 8'd0);
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (r_hs) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  rresp_d   = 2'b00;
                  arready_d = 1'b1;
                  r_state_d = R_IDLE;
               end else begin
                  beat_d  = beat_q + 8'd1;
                  rlast_d = ((beat_q + 8'd1) == arlen_q);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= 2'b00;
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rid_q     <= '0;
         rresp_q   <= 2'b00;
         rlast_q   <= 1'b0;
         arlen_q   <= 8'd0;
         beat_q    <= 8'd0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rid_q     <= rid_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
         arlen_q   <= arlen_d;
         beat_q    <= beat_d;
      end
   end

   assign s.awready = awready_q;
   assign s.wready  = wready_q;
   assign s.bvalid  = bvalid_q;
   assign s.bid     = bid_q;
   assign s.bresp   = bresp_q;
   assign s.arready = arready_q;
   assign s.rvalid  = rvalid_q;
   assign s.rid     = rid_q;
   assign s.rdata   = DATA_WIDTH'(0);
   assign s.rresp   = rresp_q;
   assign s.rlast   = rlast_q;

`ifdef AXI_DEFSLV_ERRLOG_EN
   logic [15:0]           err_cnt_q,  err_cnt_d;
   logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
   logic [16:0]           err_sum;

   // Saturating count of accepted AW/AR; AWADDR takes priority for the captured address.
   always_comb begin
      err_sum    = 17'(err_cnt_q) + 17'(aw_hs) + 17'(ar_hs);
      err_cnt_d  = (err_sum > 17'h0FFFF) ? 16'hFFFF : err_sum[15:0];
      err_addr_d = err_addr_q;
      if (aw_hs) begin
         err_addr_d = s.awaddr;
      end else if (ar_hs) begin
         err_addr_d = s.araddr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q  <= 16'h0000;
         err_addr_q <= '0;
      end else begin
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign err_cnt  = err_cnt_q;
   assign err_addr = err_addr_q;

   logic unused_ok;
   assign unused_ok = ^{s.wdata};
`else
   assign err_cnt  = 16'h0000;
   assign err_addr = '0;

   logic unused_ok;
   assign unused_ok = ^{s.wdata, s.awaddr, s.araddr};
`endif
endmodule

// File: tb/tb_axi_default_slave.sv
// Self-checking bench for axi_default_slave: transaction scoreboard plus directed literal checks.
module tb_axi_default_slave;
   localparam int unsigned IDW = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   err_cnt;
   logic [AW-1:0] err_addr;

   axi_default_slave_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   axi_default_slave #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .s        (bus.slave),
      .err_cnt  (err_cnt),
      .err_addr (err_addr)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard: outstanding B ids and expected R beats, derived from accepted requests.
   typedef struct packed {
      logic [IDW-1:0] id;
      logic           last;
   } rbeat_t;

   rbeat_t         rq[$];
   logic [IDW-1:0] bq[$];
   bit             w_open = 1'b0;
   bit             fresh  = 1'b1;
   int unsigned    m_cnt  = 0;
   logic [AW-1:0]  m_addr = '0;
   bit             aw_hs_m, w_hs_m, b_hs_m, ar_hs_m, r_hs_m;

   always @(negedge clk) begin
      if (rst) begin
         check_eq("reset_outputs",
                  64'({bus.awready, bus.wready, bus.bvalid, bus.bid, bus.bresp, bus.arready,
                       bus.rvalid, bus.rid, bus.rdata, bus.rresp, bus.rlast}), 64'd0);
         check_eq("reset_errlog", 64'({err_cnt, err_addr}), 64'd0);
         rq.delete();
         bq.delete();
         w_open = 1'b0;
         fresh  = 1'b1;
         m_cnt  = 0;
         m_addr = '0;
      end else begin
         aw_hs_m = bus.awvalid && bus.awready;
         w_hs_m  = bus.wvalid  && bus.wready;
         b_hs_m  = bus.bvalid  && bus.bready;
         ar_hs_m = bus.arvalid && bus.arready;
         r_hs_m  = bus.rvalid  && bus.rready;

         check_eq("awready", 64'(bus.awready), 64'(!fresh && bq.size() == 0 && !w_open));
         check_eq("wready",  64'(bus.wready),  64'(w_open));
         check_eq("bvalid",  64'(bus.bvalid),  64'(bq.size() > 0 && !w_open));
         check_eq("arready", 64'(bus.arready), 64'(!fresh && rq.size() == 0));
         check_eq("rvalid",  64'(bus.rvalid),  64'(rq.size() > 0));
         if (bus.bvalid && bq.size() > 0) begin
            check_eq("b_payload", 64'({bus.bid, bus.bresp}), 64'({bq[0], 2'b11}));
         end
         if (bus.rvalid && rq.size() > 0) begin
            check_eq("r_payload", 64'({bus.rid, bus.rresp, bus.rlast}),
                     64'({rq[0].id, 2'b11, rq[0].last}));
            check_eq("rdata", 64'(bus.rdata), 64'd0);
         end
`ifdef AXI_DEFSLV_ERRLOG_EN
         check_eq("err_cnt",  64'(err_cnt),  64'(m_cnt));
         check_eq("err_addr", 64'(err_addr), 64'(m_addr));
         if (aw_hs_m) m_addr = bus.awaddr;
         else if (ar_hs_m) m_addr = bus.araddr;
         m_cnt = m_cnt + 32'(aw_hs_m) + 32'(ar_hs_m);
         if (m_cnt > 32'hFFFF) m_cnt = 32'hFFFF;
`else
         check_eq("errlog_tied", 64'({err_cnt, err_addr}), 64'd0);
`endif
         if (w_hs_m && bus.wlast) w_open = 1'b0;
         if (aw_hs_m) begin
            w_open = 1'b1;
            bq.push_back(bus.awid);
         end
         if (b_hs_m && bq.size() > 0) void'(bq.pop_front());
         if (ar_hs_m) begin
            for (int i = 0; i <= int'(bus.arlen); i++) begin
               rq.push_back('{id: bus.arid, last: (i == int'(bus.arlen))});
            end
         end
         if (r_hs_m && rq.size() > 0) void'(rq.pop_front());
         fresh = 1'b0;
      end
   end

   logic [IDW-1:0] cap_bid;
   logic [1:0]     cap_bresp;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // sel: 0 AW, 1 W, 2 B, 3 AR, 4 R; returns one cycle after the handshake edge
   task automatic wait_hs(input int sel, input string name);
      bit hs;
      int n;
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 300) begin
         @(negedge clk);
         case (sel)
            0: hs = bus.awvalid && bus.awready;
            1: hs = bus.wvalid  && bus.wready;
            2: begin
               hs = bus.bvalid && bus.bready;
               cap_bid   = bus.bid;
               cap_bresp = bus.bresp;
            end
            3: hs = bus.arvalid && bus.arready;
            4: hs = bus.rvalid  && bus.rready;
            default: hs = 1'b0;
         endcase
         tick();
         n++;
      end
      check_eq({name, "_handshake"}, 64'(hs), 64'd1);
   endtask

   task automatic aw_phase(input logic [IDW-1:0] id, input logic [AW-1:0] addr);
      bus.awvalid = 1'b1;
      bus.awid    = id;
      bus.awaddr  = addr;
      wait_hs(0, "aw");
      bus.awvalid = 1'b0;
   endtask

   task automatic w_phase(input int n);
      for (int i = 0; i < n; i++) begin
         bus.wvalid = 1'b1;
         bus.wdata  = $urandom;
         bus.wlast  = (i == n - 1);
         wait_hs(1, "w");
      end
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
   endtask

   task automatic b_phase(input int delay);
      bus.bready = 1'b0;
      repeat (delay) tick();
      bus.bready = 1'b1;
      wait_hs(2, "b");
      bus.bready = 1'b0;
   endtask

   task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input bit toggle, output int beats, output int last_pos);
      int n;
      bit done;
      bus.arvalid = 1'b1;
      bus.arid    = id;
      bus.araddr  = addr;
      bus.arlen   = len;
      wait_hs(3, "ar");
      bus.arvalid = 1'b0;
      beats    = 0;
      last_pos = -1;
      n        = 0;
      done     = 1'b0;
      while (!done && n < 1000) begin
         bus.rready = toggle ? ((n % 2) == 0) : 1'b1;
         @(negedge clk);
         if (bus.rvalid && bus.rready) begin
            if (bus.rlast) begin
               last_pos = beats;
               done     = 1'b1;
            end
            beats++;
         end
         tick();
         n++;
      end
      bus.rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats, lpos, beats2, lpos2;
      bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0;
      bus.wvalid  = 1'b0; bus.wdata = '0; bus.wlast = 1'b0;
      bus.bready  = 1'b0;
      bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
      bus.rready  = 1'b0;

      // 1: reset, then ready one edge after release
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check_eq("ready_before_edge", 64'({bus.awready, bus.arready}), 64'd0);
      tick();
      check_eq("ready_after_edge", 64'({bus.awready, bus.arready}), 64'b11);

      // 2: single-beat write; an early W beat must wait for AW
      bus.wvalid = 1'b1;
      bus.wlast  = 1'b1;
      bus.wdata  = 32'hDEAD_BEEF;
      repeat (3) begin
         @(negedge clk);
         check_eq("w_before_aw", 64'(bus.wready), 64'd0);
         tick();
      end
      bus.bready = 1'b1;
      aw_phase(4'h3, 32'h5000_0010);
      wait_hs(1, "w_single");
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      b_phase(0);
      check_eq("b_single_id", 64'({cap_bid, cap_bresp}), 64'({4'h3, 2'b11}));
      check_eq("b_pulse", 64'(bus.bvalid), 64'd0);

      // 3: ARLEN=3 burst with RREADY toggling
      do_read(4'hA, 32'h5000_0100, 8'd3, 1'b1, beats, lpos);
      check_eq("r_burst_beats", 64'(beats), 64'd4);
      check_eq("r_burst_last",  64'(lpos),  64'd3);

      // 4: AW and AR accepted together, both complete
      fork
         begin
            aw_phase(4'h7, 32'h6000_0040);
            w_phase(3);
            b_phase(2);
         end
         do_read(4'h2, 32'h8000_0000, 8'd2, 1'b0, beats2, lpos2);
      join
      check_eq("conc_b_id", 64'(cap_bid), 64'h7);
      check_eq("conc_r_beats", 64'(beats2), 64'd3);
`ifdef AXI_DEFSLV_ERRLOG_EN
      check_eq("conc_err_cnt",  64'(err_cnt),  64'd4);
      check_eq("conc_err_addr", 64'(err_addr), 64'h6000_0040);
`else
      check_eq("conc_err_off", 64'({err_cnt, err_addr}), 64'd0);
`endif

      // 5: B backpressure for 10 cycles with a pending AW
      aw_phase(4'h5, 32'h9000_0000);
      w_phase(2);
      bus.awvalid = 1'b1;
      bus.awid    = 4'h6;
      bus.awaddr  = 32'h9000_0100;
      repeat (10) begin
         @(negedge clk);
         check_eq("b_stall", 64'({bus.bvalid, bus.bid, bus.bresp, bus.awready}),
                  64'({1'b1, 4'h5, 2'b11, 1'b0}));
         tick();
      end
      b_phase(0);
      check_eq("b_stall_id", 64'(cap_bid), 64'h5);
      wait_hs(0, "aw_after_b");
      bus.awvalid = 1'b0;
      w_phase(1);
      b_phase(0);
      check_eq("b_second_id", 64'(cap_bid), 64'h6);

      // ARLEN=255: 256 beats, RLAST only on the final one
      do_read(4'hF, 32'hA000_0000, 8'd255, 1'b0, beats, lpos);
      check_eq("r_max_beats", 64'(beats), 64'd256);
      check_eq("r_max_last",  64'(lpos),  64'd255);

      // 6: reset during beat 2 of ARLEN=7, then a single-beat read
      bus.arvalid = 1'b1;
      bus.arid    = 4'h9;
      bus.araddr  = 32'hB000_0000;
      bus.arlen   = 8'd7;
      wait_hs(3, "ar_rst");
      bus.arvalid = 1'b0;
      bus.rready  = 1'b1;
      wait_hs(4, "r_beat1");
      check_eq("rvalid_before_rst", 64'(bus.rvalid), 64'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_async_rvalid", 64'({bus.rvalid, bus.rlast, bus.rid}), 64'd0);
      bus.rready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      do_read(4'h1, 32'hC000_0000, 8'd0, 1'b0, beats, lpos);
      check_eq("r_after_rst_beats", 64'(beats), 64'd1);
      check_eq("r_after_rst_last",  64'(lpos),  64'd0);
`ifdef AXI_DEFSLV_ERRLOG_EN
      check_eq("err_cnt_after_rst", 64'(err_cnt), 64'd1);
`endif
      repeat (3) tick();
      check_eq("sb_drained", 64'(rq.size() + bq.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
